// File: rtl/packet_timer_if.sv
// Handshake and timing bundle between a packet_timer and its controller.
interface packet_timer_if #(
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned BITS_W = 4
);
  logic              enable_timer;
  logic              abort;
  logic [DIV_W-1:0]  clk_per_bit;
  logic [BITS_W-1:0] bits_per_packet;
  logic              sample_strobe;
  logic              shift_strobe;
  logic [BITS_W-1:0] bit_index;
  logic              busy;
  logic              packet_done;

  modport master (
    output enable_timer, abort, clk_per_bit, bits_per_packet,
    input  sample_strobe, shift_strobe, bit_index, busy, packet_done
  );

  modport slave (
    input  enable_timer, abort, clk_per_bit, bits_per_packet,
    output sample_strobe, shift_strobe, bit_index, busy, packet_done
  );
endinterface

// File: rtl/packet_timer.sv
// Bit/packet timing generator: mid-bit sample and end-of-bit shift strobes
// for M bits of N clocks each, with abort and a one-cycle completion pulse.
module packet_timer #(
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned BITS_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  packet_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  cyc_q, cyc_d;
  logic [DIV_W-1:0]  n_q, n_d;
  logic [BITS_W-1:0] idx_q, idx_d;
  logic [BITS_W-1:0] m_q, m_d;

  logic [DIV_W-1:0]  n_eff_c;
  logic [BITS_W-1:0] m_eff_c;
  logic              at_sample_c;
  logic              at_shift_c;
  logic              last_bit_c;

  // Clamp the requested geometry and decode positions from the registered counters.
  always_comb begin
    n_eff_c     = (bus.clk_per_bit < DIV_W'(2)) ? DIV_W'(2) : bus.clk_per_bit;
    m_eff_c     = (bus.bits_per_packet == '0) ? BITS_W'(1) : bus.bits_per_packet;
    at_sample_c = (state_q == COUNT) && (cyc_q == (n_q >> 1));
    at_shift_c  = (state_q == COUNT) && (cyc_q == n_q);
    last_bit_c  = (idx_q == (m_q - BITS_W'(1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      m_q     <= m_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    n_d     = n_q;
    idx_d   = idx_q;
    m_d     = m_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable_timer && !bus.abort) begin
          state_d = COUNT;
          cyc_d   = DIV_W'(1);
          idx_d   = '0;
          n_d     = n_eff_c;
          m_d     = m_eff_c;
        end
      end
      COUNT: begin
        if (bus.abort) begin
          state_d = IDLE;
          cyc_d   = '0;
        end else if (cyc_q == n_q) begin
          cyc_d = DIV_W'(1);
          if (last_bit_c) state_d = DONE;
          else            idx_d   = idx_q + BITS_W'(1);
        end else begin
          cyc_d = cyc_q + DIV_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cyc_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Abort masks the strobes of the bit it cuts short so no partial bit is consumed.
  always_comb begin
    bus.sample_strobe = at_sample_c && !bus.abort;
    bus.shift_strobe  = at_shift_c && !bus.abort;
    bus.busy          = (state_q != IDLE);
    bus.packet_done   = (state_q == DONE);
    bus.bit_index     = idx_q;
  end

endmodule
